sync_rr_sched: RTL

Round-robin scheduler that shares one W-bit, STAGES-deep synchronizing register chain between N requesters. Each transfer follows the same sequence: grant one requester, capture its data into the chain, wait out the chain latency, then present the result with the requester's ID. The block sits between several asynchronous-domain producers and a single consumer that accepts one synchronized word at a time.

---
 rtl/sync_rr_sched_if.sv | 25 ++
 rtl/sync_rr_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sync_rr_sched_if.sv
// Bundle of request/data inputs and synchronized-result outputs for sync_rr_sched.
// master: the requester/consumer side. slave: the scheduler itself.
interface sync_rr_sched_if #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [IW-1:0]  q_id;
    logic           busy;

    modport master (
        output req, d,
        input  gnt, q, q_valid, q_id, busy
    );

    modport slave (
        input  req, d,
        output gnt, q, q_valid, q_id, busy
    );
endinterface

// File: rtl/sync_rr_sched.sv
// Round-robin scheduler sharing one STAGES-deep synchronizing register chain
// between N requesters. One transfer at a time: grant, capture, wait out the
// chain latency, then present the word together with its owner's ID.
module sync_rr_sched #(
    parameter int N      = 4,
    parameter int W      = 4,
    parameter int STAGES = 2,
    parameter int IW     = $clog2(N)
) (
    input  logic          c,
    input  logic          reset_n,
    sync_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    localparam int CW        = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int WAIT_LAST = (STAGES > 1) ? STAGES - 2 : 0;

    state_t        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] sel_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  stage_q [STAGES];
    logic [N-1:0]  gnt_q;
    logic [W-1:0]  q_q;
    logic          q_valid_q;
    logic [IW-1:0] q_id_q;

    logic [IW-1:0] pick_d;
    logic          pick_vld_d;
    logic [IW-1:0] idx;

    // Rotating priority search: first requester at or after ptr wins.
    // Walking backwards lets the closest candidate overwrite the others.
    always_comb begin
        pick_d     = '0;
        pick_vld_d = 1'b0;
        idx        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (bus.req[idx]) begin
                pick_d     = idx;
                pick_vld_d = 1'b1;
            end
        end
    end

    // Transfer sequencer with registered grant/result outputs. Arbitration is
    // held off while q_valid is up so successive transfers are STAGES+3 apart.
    always_ff @(posedge c or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_id_q    <= '0;
        end else begin
            gnt_q     <= '0;
            q_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d && !q_valid_q) begin
                        sel_q   <= pick_d;
                        gnt_q   <= N'(1) << pick_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q <= '0;
                    if (STAGES == 1) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(WAIT_LAST)) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    q_q       <= stage_q[STAGES-1];
                    q_id_q    <= sel_q;
                    q_valid_q <= 1'b1;
                    ptr_q     <= (sel_q == IW'(N - 1)) ? '0 : sel_q + 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Shared chain: stage 0 takes only the granted slice, later stages shift during WAIT.
    always_ff @(posedge c or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < STAGES; j++) begin
                stage_q[j] <= '0;
            end
        end else begin
            if (state_q == LOAD) begin
                stage_q[0] <= bus.d[sel_q*W +: W];
            end
            if (state_q == WAIT) begin
                for (int j = 1; j < STAGES; j++) begin
                    stage_q[j] <= stage_q[j-1];
                end
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.q_id    = q_id_q;
    assign bus.busy    = (state_q != IDLE);
endmodule
